// File: rtl/tuner_disp_pkg.sv
// Shared display constants, colours and state encoding for the tuner overlay.
// Also holds the cents clamp used when a pitch measurement is captured.
package tuner_disp_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int NOTE_COUNT = 12;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2,
        FADE  = 2'd3
    } tuner_state_e;

    function automatic logic signed [7:0] clamp_cents(input logic signed [7:0] c);
        if (c > 8'sd50)
            return 8'sd50;
        else if (c < -8'sd50)
            return -8'sd50;
        return c;
    endfunction

endpackage

// File: rtl/tuner_square_hit.sv
// Registered pixel-in-box comparator: one cycle after pix_x/pix_y, hit says
// whether that pixel lies inside the inclusive box and en was high.
module tuner_square_hit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [9:0] x_lo,
    input  logic [9:0] x_hi,
    input  logic [9:0] y_lo,
    input  logic [9:0] y_hi,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       hit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit <= 1'b0;
        else
            hit <= en && (pix_x >= x_lo) && (pix_x <= x_hi)
                      && (pix_y >= y_lo) && (pix_y <= y_hi);
    end

endmodule

// File: rtl/tuner_square_ctrl.sv
// Frame-synchronous tuner indicator square: buffers one pitch measurement,
// slews the square toward its target each frame and sequences IDLE/TRACK/LOCK/FADE.
module tuner_square_ctrl
    import tuner_disp_pkg::*;
#(
    parameter int H_CENTER      = 320,
    parameter int PX_PER_CENT   = 2,
    parameter int SQ_HALF_W     = 5,
    parameter int SQ_Y_T        = 200,
    parameter int SQ_Y_B        = 250,
    parameter int STEP_MAX      = 4,
    parameter int IN_TUNE_CENTS = 5,
    parameter int LOCK_FRAMES   = 8,
    parameter int HOLD_FRAMES   = 60,
    parameter int FADE_FRAMES   = 30,
    parameter int BLINK_FRAMES  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       meas_valid,
    output logic       meas_ready,
    input  logic [3:0] meas_note,
    input  logic [7:0] meas_cents,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       square_on,
    output logic [2:0] square_rgb,
    output logic [3:0] note_idx,
    output logic       in_tune
);

    localparam int LW = $clog2(LOCK_FRAMES + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int FW = $clog2(FADE_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    tuner_state_e    state, state_n;
    logic [9:0]      cur_x, cur_x_n, tgt_x, tgt_x_n;
    logic [3:0]      note_n;
    logic [LW-1:0]   lock_cnt, lock_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [FW-1:0]   fade_cnt, fade_n;
    logic [BW-1:0]   blink_cnt, blink_cnt_n;
    logic            blink_on, blink_on_n;

    logic            pend_full, pend_tune;
    logic [3:0]      pend_note;
    logic [9:0]      pend_x;

    logic signed [7:0]  cents_c;
    logic signed [10:0] raw_x;
    logic [9:0]         in_x;
    logic               in_tune_beat;
    logic               xfer, take, apply, note_chg;
    logic [3:0]         app_note;
    logic [9:0]         app_x;
    logic               app_tune;

    always_comb begin
        cents_c = clamp_cents(meas_cents);
        raw_x   = 11'(H_CENTER) + 11'(PX_PER_CENT) * 11'(cents_c);
        if (raw_x < 11'(SQ_HALF_W))
            in_x = 10'(SQ_HALF_W);
        else if (raw_x > 11'(SCREEN_W - 1 - SQ_HALF_W))
            in_x = 10'(SCREEN_W - 1 - SQ_HALF_W);
        else
            in_x = raw_x[9:0];
        in_tune_beat = (cents_c <= 8'(IN_TUNE_CENTS)) && (cents_c >= -8'(IN_TUNE_CENTS));
    end

    // Handshake: a beat transfers when meas_valid && meas_ready; ready is low only
    // while the single pending slot is full. Out-of-range notes are acked and dropped.
    assign meas_ready = !pend_full;
    assign xfer       = meas_valid && meas_ready;
    assign take       = xfer && (meas_note < 4'(NOTE_COUNT));
    assign apply      = frame_tick && (pend_full || take);
    assign app_note   = pend_full ? pend_note : meas_note;
    assign app_x      = pend_full ? pend_x    : in_x;
    assign app_tune   = pend_full ? pend_tune : in_tune_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
            pend_note <= '0;
            pend_x    <= '0;
            pend_tune <= 1'b0;
        end else if (frame_tick) begin
            pend_full <= 1'b0;
        end else if (take) begin
            pend_full <= 1'b1;
            pend_note <= meas_note;
            pend_x    <= in_x;
            pend_tune <= in_tune_beat;
        end
    end

    function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
        if (tgt > cur + 10'(STEP_MAX))
            return cur + 10'(STEP_MAX);
        else if (cur > tgt + 10'(STEP_MAX))
            return cur - 10'(STEP_MAX);
        return tgt;
    endfunction

    always_comb begin
        state_n     = state;
        cur_x_n     = cur_x;
        tgt_x_n     = tgt_x;
        note_n      = note_idx;
        lock_n      = lock_cnt;
        hold_n      = hold_cnt;
        fade_n      = fade_cnt;
        blink_cnt_n = blink_cnt;
        blink_on_n  = blink_on;
        note_chg    = 1'b0;
        if (frame_tick) begin
            note_chg = apply && ((app_note != note_idx) || (state == IDLE));
            if (apply) begin
                tgt_x_n = app_x;
                note_n  = app_note;
            end
            cur_x_n = note_chg ? app_x : step_toward(cur_x, tgt_x_n);
            case (state)
                IDLE: begin
                    if (apply) begin
                        state_n = TRACK;
                        lock_n  = '0;
                        hold_n  = '0;
                    end
                end
                TRACK, LOCK: begin
                    if (apply) begin
                        hold_n = '0;
                        if (note_chg || !app_tune) begin
                            // A new note has not earned lock yet, so LOCK drops back too.
                            lock_n  = '0;
                            state_n = TRACK;
                        end else if (state == TRACK) begin
                            lock_n = lock_cnt + 1'b1;
                            if (lock_n == LW'(LOCK_FRAMES))
                                state_n = LOCK;
                        end
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                        if (hold_n == HW'(HOLD_FRAMES)) begin
                            state_n     = FADE;
                            fade_n      = '0;
                            blink_cnt_n = '0;
                            blink_on_n  = 1'b1;
                        end
                    end
                end
                FADE: begin
                    if (apply) begin
                        state_n    = TRACK;
                        lock_n     = '0;
                        hold_n     = '0;
                        fade_n     = '0;
                        blink_on_n = 1'b1;
                    end else begin
                        fade_n = fade_cnt + 1'b1;
                        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                            blink_cnt_n = '0;
                            blink_on_n  = !blink_on;
                        end else begin
                            blink_cnt_n = blink_cnt + 1'b1;
                        end
                        if (fade_n == FW'(FADE_FRAMES)) begin
                            state_n    = IDLE;
                            fade_n     = '0;
                            blink_on_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_x     <= 10'(H_CENTER);
            tgt_x     <= 10'(H_CENTER);
            note_idx  <= '0;
            lock_cnt  <= '0;
            hold_cnt  <= '0;
            fade_cnt  <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            state     <= state_n;
            cur_x     <= cur_x_n;
            tgt_x     <= tgt_x_n;
            note_idx  <= note_n;
            lock_cnt  <= lock_n;
            hold_cnt  <= hold_n;
            fade_cnt  <= fade_n;
            blink_cnt <= blink_cnt_n;
            blink_on  <= blink_on_n;
        end
    end

    always_comb begin
        case (state)
            TRACK:   square_rgb = RED;
            LOCK:    square_rgb = GREEN;
            FADE:    square_rgb = RED;
            default: square_rgb = BLACK;
        endcase
    end

    assign in_tune = (state == LOCK);

    tuner_square_hit u_hit (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((state != IDLE) && blink_on),
        .x_lo  (cur_x - 10'(SQ_HALF_W)),
        .x_hi  (cur_x + 10'(SQ_HALF_W)),
        .y_lo  (10'(SQ_Y_T)),
        .y_hi  (10'(SQ_Y_B)),
        .pix_x (pix_x),
        .pix_y (pix_y),
        .hit   (square_on)
    );

endmodule

// File: tb/tb_tuner_square_ctrl.sv
// Directed bench for tuner_square_ctrl: a vector table for tracking/lock/clamp
// behaviour plus hand sequences for handshake, pixel bounds, fade blink and reset.
module tb_tuner_square_ctrl;
    import tuner_disp_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       meas_valid;
    logic       meas_ready;
    logic [3:0] meas_note;
    logic [7:0] meas_cents;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       square_on;
    logic [2:0] square_rgb;
    logic [3:0] note_idx;
    logic       in_tune;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tuner_square_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .meas_note  (meas_note),
        .meas_cents (meas_cents),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .square_on  (square_on),
        .square_rgb (square_rgb),
        .note_idx   (note_idx),
        .in_tune    (in_tune)
    );

    typedef struct {
        bit           do_send;
        logic [3:0]   note;
        int           cents;
        int           ticks;
        int           exp_x;
        tuner_state_e exp_state;
        logic [2:0]   exp_rgb;
        bit           exp_tune;
        int           exp_note;
        int           exp_lock;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(bit s, logic [3:0] n, int c, int t, int x,
                                tuner_state_e st, logic [2:0] rgb, bit tn, int en, int lk);
        vec_t v;
        v.do_send = s; v.note = n; v.cents = c; v.ticks = t; v.exp_x = x;
        v.exp_state = st; v.exp_rgb = rgb; v.exp_tune = tn; v.exp_note = en; v.exp_lock = lk;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] n, input int c);
        int waited = 0;
        while (!meas_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!meas_ready) check("send_ready_timeout", 0, 1);
        meas_valid = 1'b1;
        meas_note  = n;
        meas_cents = 8'(c);
        @(posedge clk); #1;
        meas_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic pix_chk(input string name, input int x, input int y, input int exp);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(posedge clk); #1;
        check(name, int'(square_on), exp);
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; meas_valid = 1'b0;
        meas_note = '0; meas_cents = '0; pix_x = '0; pix_y = '0;

        vecs[0]  = mk(1, 9,   10, 1, 340, TRACK, RED,   0, 9, 0);
        vecs[1]  = mk(1, 9,  -10, 1, 336, TRACK, RED,   0, 9, 0);
        vecs[2]  = mk(0, 9,    0, 1, 332, TRACK, RED,   0, 9, 0);
        vecs[3]  = mk(0, 9,    0, 3, 320, TRACK, RED,   0, 9, 0);
        vecs[4]  = mk(0, 9,    0, 5, 300, TRACK, RED,   0, 9, 0);
        vecs[5]  = mk(0, 9,    0, 2, 300, TRACK, RED,   0, 9, 0);
        vecs[6]  = mk(1, 9,    3, 1, 304, TRACK, RED,   0, 9, 1);
        vecs[7]  = mk(1, 9,    3, 1, 308, TRACK, RED,   0, 9, 2);
        vecs[8]  = mk(1, 9,    3, 1, 312, TRACK, RED,   0, 9, 3);
        vecs[9]  = mk(1, 9,    3, 1, 316, TRACK, RED,   0, 9, 4);
        vecs[10] = mk(1, 9,    3, 1, 320, TRACK, RED,   0, 9, 5);
        vecs[11] = mk(1, 9,    3, 1, 324, TRACK, RED,   0, 9, 6);
        vecs[12] = mk(1, 9,    3, 1, 326, TRACK, RED,   0, 9, 7);
        vecs[13] = mk(1, 9,    3, 1, 326, LOCK,  GREEN, 1, 9, 8);
        vecs[14] = mk(1, 9,   20, 1, 330, TRACK, RED,   0, 9, 0);
        vecs[15] = mk(1, 4,  -25, 1, 270, TRACK, RED,   0, 4, 0);
        vecs[16] = mk(1, 7,  120, 1, 420, TRACK, RED,   0, 7, 0);
        vecs[17] = mk(1, 2, -128, 1, 220, TRACK, RED,   0, 2, 0);
        vecs[18] = mk(1, 15,   0, 1, 220, TRACK, RED,   0, 2, 0);
        vecs[19] = mk(1, 2,    5, 1, 224, TRACK, RED,   0, 2, 1);
        vecs[20] = mk(1, 2,    6, 1, 228, TRACK, RED,   0, 2, 0);
        vecs[21] = mk(1, 2,   -5, 1, 232, TRACK, RED,   0, 2, 1);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(dut.state), int'(IDLE));
        check("rst_cur_x", int'(dut.cur_x), 320);
        check("rst_ready", int'(meas_ready), 1);
        check("rst_square_on", int'(square_on), 0);
        check("rst_rgb", int'(square_rgb), 0);
        check("rst_note", int'(note_idx), 0);
        check("rst_in_tune", int'(in_tune), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].do_send) send(vecs[i].note, vecs[i].cents);
            for (int t = 0; t < vecs[i].ticks; t++) tick();
            check($sformatf("v%0d_cur_x", i), int'(dut.cur_x), vecs[i].exp_x);
            check($sformatf("v%0d_state", i), int'(dut.state), int'(vecs[i].exp_state));
            check($sformatf("v%0d_rgb", i), int'(square_rgb), int'(vecs[i].exp_rgb));
            check($sformatf("v%0d_in_tune", i), int'(in_tune), int'(vecs[i].exp_tune));
            check($sformatf("v%0d_note", i), int'(note_idx), vecs[i].exp_note);
            check($sformatf("v%0d_lock_cnt", i), int'(dut.lock_cnt), vecs[i].exp_lock);
        end

        // Stall while pending is full; stalled beat accepted the cycle after the tick
        meas_valid = 1'b1; meas_note = 4'd2; meas_cents = 8'd0;
        @(posedge clk); #1;
        check("hs_ready_full", int'(meas_ready), 0);
        meas_note = 4'd5; meas_cents = 8'd10;
        repeat (2) begin @(posedge clk); #1; end
        check("hs_ready_stall", int'(meas_ready), 0);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("hs_tick_cur_x", int'(dut.cur_x), 236);
        check("hs_tick_note", int'(note_idx), 2);
        check("hs_ready_after_tick", int'(meas_ready), 1);
        @(posedge clk); #1;
        meas_valid = 1'b0;
        check("hs_stalled_taken", int'(meas_ready), 0);
        tick();
        check("hs_stalled_cur_x", int'(dut.cur_x), 340);
        check("hs_stalled_note", int'(note_idx), 5);

        // Bypass: transfer on the tick cycle with an empty buffer
        meas_valid = 1'b1; meas_note = 4'd5; meas_cents = 8'(-10);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        meas_valid = 1'b0; frame_tick = 1'b0;
        check("byp_cur_x", int'(dut.cur_x), 336);
        check("byp_ready", int'(meas_ready), 1);

        // Pixel bounds around cur_x=336, rows 200..250
        pix_chk("pix_center", 336, 225, 1);
        pix_chk("pix_x_hi_in", 341, 225, 1);
        pix_chk("pix_x_hi_out", 342, 225, 0);
        pix_chk("pix_x_lo_in", 331, 225, 1);
        pix_chk("pix_x_lo_out", 330, 225, 0);
        pix_chk("pix_y_t_in", 336, 200, 1);
        pix_chk("pix_y_t_out", 336, 199, 0);
        pix_chk("pix_y_b_in", 336, 250, 1);
        pix_chk("pix_y_b_out", 336, 251, 0);
        pix_chk("pix_lat_set", 336, 225, 1);
        pix_x = 10'd400;
        check("pix_lat_hold", int'(square_on), 1);
        @(posedge clk); #1;
        check("pix_lat_update", int'(square_on), 0);

        // Hold expiry into FADE, blink 5 on / 5 off, then IDLE
        repeat (59) tick();
        check("hold59_state", int'(dut.state), int'(TRACK));
        check("hold59_cur_x", int'(dut.cur_x), 300);
        tick();
        check("fade_state", int'(dut.state), int'(FADE));
        check("fade_rgb", int'(square_rgb), int'(RED));
        check("fade_in_tune", int'(in_tune), 0);
        pix_chk("fade_k0_on", 300, 225, 1);
        for (int k = 1; k <= 30; k++) begin
            int exp_on;
            tick();
            @(posedge clk); #1;
            exp_on = (k == 30) ? 0 : (((k / 5) % 2) == 0 ? 1 : 0);
            check($sformatf("fade_k%0d_on", k), int'(square_on), exp_on);
            if (k == 29) check("fade_k29_state", int'(dut.state), int'(FADE));
        end
        check("fade_end_state", int'(dut.state), int'(IDLE));
        check("fade_end_rgb", int'(square_rgb), 0);

        // Lock, then reset mid-cycle with a pending beat
        send(4'd3, 2);
        tick();
        check("e_entry_cur_x", int'(dut.cur_x), 324);
        for (int j = 0; j < 8; j++) begin
            send(4'd3, 2);
            tick();
        end
        check("e_lock_in_tune", int'(in_tune), 1);
        check("e_lock_rgb", int'(square_rgb), int'(GREEN));
        send(4'd3, 2);
        check("e_pend_ready", int'(meas_ready), 0);
        pix_chk("e_pix_on", 324, 225, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("e_rst_in_tune", int'(in_tune), 0);
        check("e_rst_rgb", int'(square_rgb), 0);
        check("e_rst_square_on", int'(square_on), 0);
        check("e_rst_ready", int'(meas_ready), 1);
        check("e_rst_note", int'(note_idx), 0);
        check("e_rst_cur_x", int'(dut.cur_x), 320);
        check("e_rst_state", int'(dut.state), int'(IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check("e_post_state", int'(dut.state), int'(IDLE));
        @(posedge clk); #1;
        check("e_post_square_on", int'(square_on), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tuner_square_ctrl.md
Name: tuner_square_ctrl

Overview:
Frame-synchronous controller for the tuner's indicator square on the VGA overlay. It accepts pitch measurements (note index plus cents deviation) through a valid/ready handshake and slews the square's horizontal position toward the target once per frame. It sequences display state (hidden, tracking, locked, fading) and drives the square's pixel coverage and colour. It sits between the pitch-detection path and the pixel mux.

Parameters:
H_CENTER, 320, x pixel of the square centre at 0 cents
PX_PER_CENT, 2, horizontal pixels per cent of deviation
SQ_HALF_W, 5, half-width of the square in pixels
SQ_Y_T, 200, top row of the square (inclusive)
SQ_Y_B, 250, bottom row of the square (inclusive)
STEP_MAX, 4, maximum x movement per frame in pixels
IN_TUNE_CENTS, 5, |cents| at or below this counts as in tune
LOCK_FRAMES, 8, consecutive in-tune frames required to enter LOCK
HOLD_FRAMES, 60, frames without a new measurement before FADE
FADE_FRAMES, 30, frames spent in FADE before returning to IDLE
BLINK_FRAMES, 5, half-period of the FADE blink, in frames

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse at the start of vertical blank
meas_valid  in  1  measurement available
meas_ready  out  1  controller can accept a measurement
meas_note  in  4  note index 0..11 (12..15 ignored: beat dropped, still acknowledged)
meas_cents  in  8  signed cents deviation, two's complement
pix_x  in  10  current pixel column
pix_y  in  10  current pixel row
square_on  out  1  current pixel lies inside the square (registered)
square_rgb  out  3  square colour
note_idx  out  4  currently displayed note
in_tune  out  1  high while in LOCK

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pending buffer empty, meas_ready=1, cur_x=H_CENTER, note_idx=0, in_tune=0, square_on=0, square_rgb=3'b000, all counters 0. Reset asserted mid-frame takes effect immediately; the pending measurement is discarded.
- Handshake: a measurement transfers on a cycle where meas_valid and meas_ready are both 1. The pending buffer is one entry deep. meas_ready = !pending_full.
- Capture: meas_cents is clamped to [-50,+50]. target_x = H_CENTER + cents*PX_PER_CENT, computed 11-bit signed, then clamped to [SQ_HALF_W, 639-SQ_HALF_W].
- frame_tick: consumes pending, which becomes empty. If pending is empty and a transfer occurs in the same cycle, the incoming beat is applied directly (bypass). A transfer arriving when pending is full is not possible because ready=0.
- Position update on frame_tick: cur_x moves toward target_x by min(|target_x-cur_x|, STEP_MAX). A note change (new note != note_idx, or entry from IDLE) makes cur_x jump to target_x and clears lock_cnt.
- FSM, evaluated on frame_tick only:
  - IDLE: on an applied measurement -> TRACK.
  - TRACK: lock_cnt increments on in-tune applied measurements and clears on out-of-tune ones; lock_cnt==LOCK_FRAMES -> LOCK.
  - LOCK: an out-of-tune measurement -> TRACK with lock_cnt=0.
  - TRACK or LOCK: hold_cnt counts frames without an applied measurement and resets on apply; hold_cnt==HOLD_FRAMES -> FADE.
  - FADE: an applied measurement -> TRACK; fade_cnt==FADE_FRAMES -> IDLE.
- Colour: IDLE 000; TRACK 100 (red); LOCK 010 (green); FADE 100, with square_on gated off during alternate BLINK_FRAMES windows.
- Pixel path: square_on is registered, with 1-cycle latency from pix_x/pix_y. It is 1 iff state!=IDLE, cur_x-SQ_HALF_W <= pix_x <= cur_x+SQ_HALF_W, SQ_Y_T <= pix_y <= SQ_Y_B, and the blink window is on. cur_x, square_rgb and note_idx change only on frame_tick, so there is no tearing.
- in_tune=1 exactly while state==LOCK.

Decomposition:
- Shared package tuner_disp_pkg: screen constants (640x480), colour constants (RED, GREEN, BLACK), state enum {IDLE, TRACK, LOCK, FADE}, note count 12.
- One sub-module: tuner_square_hit. It is a registered pixel-in-box comparator (bounds in, square_on out) and is reusable by other overlay elements.

Test Plan:
- Reset, then note=9, cents=+10, then 1 frame_tick -> state TRACK, cur_x=340 (jump), square_rgb=100; pixel (340,225) gives square_on=1 one cycle later; pixel (346,225) gives 0.
- Same note, cents=-10, then 5 frame_ticks -> cur_x sequence 336, 332, 328, 324, 320; stays at 300 target after further ticks (300 reached after 10 total).
- cents=+3 applied on 8 consecutive frames -> in_tune=1 and rgb=010 after the 8th tick; then cents=+20 -> in_tune=0, rgb=100 on that tick.
- Second meas_valid while pending is full -> meas_ready=0, beat stalled; it is accepted on the cycle after frame_tick. A transfer coinciding with frame_tick on an empty buffer is applied on that tick.
- No measurements for 60 frames -> FADE with square blinking 5 on/5 off; 30 more frames -> IDLE, square_on=0. cents=+120 is clamped to target 420.
- rst_n low mid-frame in LOCK -> outputs return to reset values asynchronously the same cycle; pending dropped, meas_ready=1.
